// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with a word-addressed data memory of configurable latency
// Ports: clk/rst (async, active-high); EX/MEM inputs wb_ctl, branch, memread, memwrite,
//   EX_MEM_NPC, zero, alu_result, rdata2out, five_bit_muxout; fetch outputs pcsrc, pc_target;
//   stall to upstream; MEM/WB outputs mem_wb_ctl, mem_read_data, mem_alu_result, mem_write_reg;
//   sticky misalign flag.
// Optional feature: define MEM_STAGE_MISALIGN_TRAP_EN to suppress misaligned memory ops and
//   raise misalign; otherwise low address bits are ignored and misalign stays 0.
module mem_stage #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wb_ctl,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] EX_MEM_NPC,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2out,
    input  logic [4:0]  five_bit_muxout,
    output logic        pcsrc,
    output logic [31:0] pc_target,
    output logic        stall,
    output logic [1:0]  mem_wb_ctl,
    output logic [31:0] mem_read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg,
    output logic        misalign
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY) + 1;
    typedef enum logic {IDLE, BUSY} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          memop, mis, ld, we;
    logic [1:0]    ctl_q;
    logic [31:0]   rdata_q, alu_q;
    logic [4:0]    wreg_q;
    logic          mis_q;
    logic          unused_ok;

    assign idx       = alu_result[AW+1:2];
    assign memop     = memread | memwrite;
    assign pcsrc     = branch & zero;
    assign pc_target = EX_MEM_NPC;
    assign unused_ok = ^{alu_result[31:AW+2], alu_result[1:0]};
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign mis = memop & (alu_result[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    // ld marks the edge at which MEM/WB takes a real (non-bubble) result
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        ld      = 1'b0;
        if (state_q == BUSY) begin
            if (cnt_q != '0) begin
                stall = 1'b1;
                cnt_d = cnt_q - CW'(1);
            end else begin
                ld      = 1'b1;
                state_d = IDLE;
            end
        end else if (memop && !mis && LATENCY > 1) begin
            stall   = 1'b1;
            state_d = BUSY;
            cnt_d   = CW'(LATENCY - 2);
        end else begin
            ld = 1'b1;
        end
        if (rst) stall = 1'b0;
    end

    // a reset edge must never commit an abandoned store
    assign we = ld & memwrite & ~mis & ~rst;

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= rdata2out;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ctl_q   <= '0;
            rdata_q <= '0;
            alu_q   <= '0;
            wreg_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ld) begin
                ctl_q   <= mis ? 2'b00 : wb_ctl;
                alu_q   <= alu_result;
                wreg_q  <= five_bit_muxout;
                rdata_q <= (memread && !mis) ? mem[idx] : '0;
                mis_q   <= mis_q | mis;
            end else begin
                ctl_q <= 2'b00;
            end
        end
    end

    assign mem_wb_ctl     = ctl_q;
    assign mem_read_data  = rdata_q;
    assign mem_alu_result = alu_q;
    assign mem_write_reg  = wreg_q;
    assign misalign       = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage at LATENCY 1 and 3
module tb_mem_stage;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    typedef struct packed {
        logic [1:0]  wb;
        logic        br;
        logic        mr;
        logic        mw;
        logic [31:0] npc;
        logic        z;
        logic [31:0] a;
        logic [31:0] wd;
        logic [4:0]  rd;
    } in_t;
    typedef struct packed {
        logic        pcsrc;
        logic [31:0] tgt;
        logic        stall;
        logic [1:0]  ctl;
        logic [31:0] data;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        mis;
    } out_t;
    typedef struct {
        in_t         x;
        logic        pcsrc;
        logic [31:0] tgt;
        logic [1:0]  ctl;
        logic [31:0] data;
        logic [31:0] alu;
        logic [4:0]  rd;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    in_t  in1 = '0;
    in_t  in3 = '0;
    out_t o [2];
    logic        pc1, st1, mi1, pc3, st3, mi3;
    logic [31:0] tg1, dt1, al1, tg3, dt3, al3;
    logic [1:0]  ct1, ct3;
    logic [4:0]  rd1, rd3;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(256), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .wb_ctl(in1.wb), .branch(in1.br), .memread(in1.mr),
        .memwrite(in1.mw), .EX_MEM_NPC(in1.npc), .zero(in1.z), .alu_result(in1.a),
        .rdata2out(in1.wd), .five_bit_muxout(in1.rd), .pcsrc(pc1), .pc_target(tg1),
        .stall(st1), .mem_wb_ctl(ct1), .mem_read_data(dt1), .mem_alu_result(al1),
        .mem_write_reg(rd1), .misalign(mi1)
    );
    mem_stage #(.DEPTH(256), .LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .wb_ctl(in3.wb), .branch(in3.br), .memread(in3.mr),
        .memwrite(in3.mw), .EX_MEM_NPC(in3.npc), .zero(in3.z), .alu_result(in3.a),
        .rdata2out(in3.wd), .five_bit_muxout(in3.rd), .pcsrc(pc3), .pc_target(tg3),
        .stall(st3), .mem_wb_ctl(ct3), .mem_read_data(dt3), .mem_alu_result(al3),
        .mem_write_reg(rd3), .misalign(mi3)
    );
    assign o[0] = {pc1, tg1, st1, ct1, dt1, al1, rd1, mi1};
    assign o[1] = {pc3, tg3, st3, ct3, dt3, al3, rd3, mi3};

    // reference model: plain memory arrays plus the expected MEM/WB contents per DUT
    logic [31:0] mm [2][256];
    logic [1:0]  e_ctl [2];
    logic [31:0] e_data [2];
    logic [31:0] e_alu [2];
    logic [4:0]  e_rd [2];
    logic        e_mis [2];
    int          lat [2] = '{1, 3};
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tbl [9];

    task automatic chk(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL u%0d_%s: got %h want %h at %0t", lat[d], nm, act, exp, $time);
        end
    endtask

    function automatic in_t mk(input logic [1:0] wb, input logic br, input logic mr, input logic mw,
                               input logic [31:0] npc, input logic z, input logic [31:0] a,
                               input logic [31:0] wd, input logic [4:0] rd);
        return {wb, br, mr, mw, npc, z, a, wd, rd};
    endfunction

    task automatic zero_model();
        for (int d = 0; d < 2; d++) begin
            e_ctl[d] = '0; e_data[d] = '0; e_alu[d] = '0; e_rd[d] = '0; e_mis[d] = 1'b0;
        end
    endtask

    task automatic check_regs(input int d);
        chk(d, "ctl", o[d].ctl, e_ctl[d]);
        chk(d, "data", o[d].data, e_data[d]);
        chk(d, "alu", o[d].alu, e_alu[d]);
        chk(d, "rd", o[d].rd, e_rd[d]);
        chk(d, "misalign", o[d].mis, e_mis[d]);
    endtask

    // Presents x until the model says the access is done; call and return at edge+1.
    task automatic run(input int d, input in_t x);
        logic memop, mis;
        int   n, idx;
        memop = x.mr | x.mw;
        mis   = TRAP && memop && (x.a[1:0] != 2'b00);
        n     = (memop && !mis) ? lat[d] : 1;
        idx   = (x.a / 4) % 256;
        if (d == 0) in1 = x; else in3 = x;
        for (int k = 0; k < n; k++) begin
            #1;
            chk(d, "stall", o[d].stall, k < n - 1);
            chk(d, "pcsrc", o[d].pcsrc, x.br & x.z);
            chk(d, "pc_target", o[d].tgt, x.npc);
            @(posedge clk);
            #1;
            if (k < n - 1) begin
                e_ctl[d] = '0;
            end else begin
                e_ctl[d]  = mis ? 2'b00 : x.wb;
                e_alu[d]  = x.a;
                e_rd[d]   = x.rd;
                e_data[d] = (x.mr && !mis) ? mm[d][idx] : '0;
                if (x.mw && !mis) mm[d][idx] = x.wd;
                e_mis[d]  = e_mis[d] | mis;
            end
            check_regs(d);
        end
    endtask

    initial begin
        tbl[0] = '{mk(2'b10, 0, 0, 0, 0, 0, 32'h1234, 0, 7), 0, 0, 2'b10, 0, 32'h1234, 7};
        tbl[1] = '{mk(2'b00, 0, 0, 1, 0, 0, 32'h10, 32'hDEADBEEF, 0), 0, 0, 2'b00, 0, 32'h10, 0};
        tbl[2] = '{mk(2'b01, 0, 1, 0, 0, 0, 32'h10, 0, 3), 0, 0, 2'b01, 32'hDEADBEEF, 32'h10, 3};
        tbl[3] = '{mk(2'b00, 1, 0, 0, 32'h40, 1, 0, 0, 0), 1, 32'h40, 2'b00, 0, 0, 0};
        tbl[4] = '{mk(2'b00, 1, 0, 0, 32'h40, 0, 0, 0, 0), 0, 32'h40, 2'b00, 0, 0, 0};
        tbl[5] = '{mk(2'b11, 0, 0, 1, 0, 0, 32'h400, 32'hA5, 9), 0, 0, 2'b11, 0, 32'h400, 9};
        tbl[6] = '{mk(2'b01, 0, 1, 0, 0, 0, 32'h0, 0, 4), 0, 0, 2'b01, 32'hA5, 0, 4};
        tbl[7] = '{mk(2'b01, 0, 1, 1, 0, 0, 32'h10, 32'h11111111, 5), 0, 0, 2'b01, 32'hDEADBEEF, 32'h10, 5};
        tbl[8] = '{mk(2'b01, 0, 1, 0, 0, 0, 32'h10, 0, 6), 0, 0, 2'b01, 32'h11111111, 32'h10, 6};
        zero_model();
        repeat (2) @(posedge clk);
        #1;
        check_regs(0);
        check_regs(1);
        in3 = mk(2'b01, 0, 1, 0, 0, 0, 32'h10, 0, 1);
        #1;
        chk(1, "stall_in_rst", o[1].stall, 0);
        in3 = '0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            foreach (tbl[i]) begin
                run(d, tbl[i].x);
                chk(d, "tbl_pcsrc", o[d].pcsrc, tbl[i].pcsrc);
                chk(d, "tbl_target", o[d].tgt, tbl[i].tgt);
                chk(d, "tbl_ctl", o[d].ctl, tbl[i].ctl);
                chk(d, "tbl_data", o[d].data, tbl[i].data);
                chk(d, "tbl_alu", o[d].alu, tbl[i].alu);
                chk(d, "tbl_rd", o[d].rd, tbl[i].rd);
            end
            run(d, '0);
        end
        // back-to-back loads each pay the full latency
        run(1, mk(2'b01, 0, 1, 0, 0, 0, 32'h10, 0, 2));
        run(1, mk(2'b10, 0, 1, 0, 0, 0, 32'h0, 0, 3));
        run(1, '0);
        // reset in the middle of a multi-cycle store leaves memory untouched
        run(1, mk(2'b00, 0, 0, 1, 0, 0, 32'h20, 32'hCAFEF00D, 0));
        run(1, '0);
        in3 = mk(2'b01, 0, 0, 1, 0, 0, 32'h20, 32'h12345678, 8);
        #1;
        chk(1, "pre_rst_stall", o[1].stall, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        zero_model();
        #1;
        chk(1, "mid_rst_stall", o[1].stall, 0);
        check_regs(1);
        in3 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run(1, mk(2'b01, 0, 1, 0, 0, 0, 32'h20, 0, 8));
        chk(1, "rst_abandon_word", o[1].data, 32'hCAFEF00D);
        run(1, '0);
        // misaligned accesses, then flag persistence across aligned ops until reset
        run(0, mk(2'b01, 0, 0, 1, 0, 0, 32'h13, 32'h77, 1));
        run(0, mk(2'b01, 0, 1, 0, 0, 0, 32'h10, 0, 2));
        run(0, mk(2'b10, 0, 0, 1, 0, 0, 32'h24, 32'h5A, 3));
        run(0, '0);
        run(1, mk(2'b11, 0, 1, 0, 0, 0, 32'h22, 0, 4));
        run(1, mk(2'b11, 0, 1, 0, 0, 0, 32'h20, 0, 5));
        run(1, '0);
        rst = 1'b1;
        zero_model();
        #1;
        check_regs(0);
        check_regs(1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // fill every word so random loads never see uninitialised storage
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++)
                run(d, mk(2'($urandom), 0, 0, 1, 0, 0, 32'(i * 4), $urandom, 5'($urandom)));
            run(d, '0);
        end
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                in_t x;
                int  r;
                r = $urandom_range(9);
                x = mk(2'($urandom), 1'($urandom), r < 4, r >= 3 && r < 7, $urandom, 1'($urandom),
                       $urandom, $urandom, 5'($urandom));
                if ($urandom_range(3) != 0) x.a[1:0] = 2'b00;
                run(d, x);
            end
            run(d, '0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage. Consumes the EX/MEM register outputs (control, ALU result, store data, destination register, branch target, zero flag).
- Performs loads and stores against an internal word-addressed data memory with a configurable access latency. While the access is in flight it stalls the upstream pipeline.
- Drives the MEM/WB pipeline register and the branch-resolution signals back to fetch.

Parameters:
- DEPTH, 256, data memory size in 32-bit words (power of 2)
- LATENCY, 1, cycles per memory access (>=1); 1 = single-cycle, no stall

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wb_ctl  in  2  EX/MEM write-back control, passed to MEM/WB
- branch  in  1  instruction is a branch
- memread  in  1  load
- memwrite  in  1  store
- EX_MEM_NPC  in  32  branch target address
- zero  in  1  ALU zero flag
- alu_result  in  32  ALU result / memory byte address
- rdata2out  in  32  store data
- five_bit_muxout  in  5  destination register
- pcsrc  out  1  take branch (to fetch)
- pc_target  out  32  branch target (to fetch)
- stall  out  1  hold EX/MEM and all earlier stages
- mem_wb_ctl  out  2  MEM/WB write-back control
- mem_read_data  out  32  MEM/WB load data
- mem_alu_result  out  32  MEM/WB ALU result
- mem_write_reg  out  5  MEM/WB destination register
- misalign  out  1  sticky misaligned-access flag (feature-dependent)

Behaviour:
- Combinational outputs:
  - pcsrc = branch & zero.
  - pc_target = EX_MEM_NPC.
  - Both are unaffected by stall.
- memop = memread | memwrite.
- Word index = alu_result[log2(DEPTH)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH words.
- If memread and memwrite are both 1, the op is treated as a store. mem_read_data then gets the pre-write word.
- FSM states IDLE and BUSY, plus counter cnt (width clog2(LATENCY)+1).
- IDLE, non-memop: at the edge, MEM/WB is loaded.
  - mem_wb_ctl <= wb_ctl
  - mem_alu_result <= alu_result
  - mem_write_reg <= five_bit_muxout
  - mem_read_data <= 0
  - stall = 0
- IDLE, memop, LATENCY==1: no stall.
  - Store: mem[idx] <= rdata2out at the edge.
  - Load: mem_read_data <= mem[idx].
  - Other MEM/WB fields load as in the non-memop case.
- IDLE, memop, LATENCY>1:
  - stall = 1 combinationally.
  - At the edge: state <= BUSY, cnt <= LATENCY-2, MEM/WB gets a bubble (mem_wb_ctl <= 0, other fields hold).
- BUSY, cnt!=0: stall = 1; cnt decrements; bubble inserted again.
- BUSY, cnt==0: stall = 0. At the edge the access completes exactly as in the LATENCY==1 case, then state <= IDLE.
- Upstream holds all inputs stable while stall = 1. The stage uses the live inputs at the completing edge.
- Total cost of a memory op: stall high for LATENCY-1 cycles, result in MEM/WB on the LATENCY-th edge after first presentation. Back-to-back memops each take the full LATENCY cycles.
- Reset (async, any state): state=IDLE, cnt=0, all MEM/WB outputs 0, misalign=0. Memory contents are not reset.
- Reset mid-access: the access is abandoned and no write occurs.
- stall is 0 while rst=1.

Optional Feature:
- Macro MEM_STAGE_MISALIGN_TRAP_EN.
- Defined:
  - A memop with alu_result[1:0]!=0 is suppressed: no write, no stall, mem_read_data <= 0, mem_wb_ctl <= 0.
  - misalign is set at that edge and stays 1 until reset.
- Undefined:
  - Low address bits are ignored and the access proceeds normally.
  - misalign is tied to 0.

Test Plan:
- Reset then non-memop: alu_result=32'h1234, wb_ctl=2'b10, rd=5'd7, LATENCY=1 -> next edge mem_alu_result=32'h1234, mem_wb_ctl=2'b10, mem_write_reg=7, stall never 1.
- LATENCY=1: store 32'hDEADBEEF to address 0x10, then load from 0x10 -> mem_read_data=32'hDEADBEEF on the edge after the load.
- LATENCY=3: load from 0x10 -> stall=1 for exactly 2 cycles, mem_wb_ctl=0 for those 2 edges, data and ctl valid on the 3rd edge.
- Branch with zero=1 and EX_MEM_NPC=32'h40 -> pcsrc=1, pc_target=32'h40 in the same cycle; with zero=0 -> pcsrc=0.
- DEPTH=256: store 32'hA5 to address 0x400 (wraps to word 0), load address 0x0 -> 32'hA5. Assert rst during a LATENCY=3 store -> stall=0 immediately and word unchanged afterward.
- With MEM_STAGE_MISALIGN_TRAP_EN: store to 0x13 -> misalign=1, memory unchanged, mem_wb_ctl=0. The flag persists through subsequent aligned ops until rst.
